// File: rtl/softmax_phase_ctrl_pkg.sv
// softmax_phase_ctrl_pkg
//   Shared definitions for the STAR softmax phase sequencer: the phase FSM
//   state encoding and the default geometry constants.  VEC_LEN and N_ROW
//   both default to the datapath input length (Input_len).
package softmax_phase_ctrl_pkg;

  localparam int unsigned Input_len   = 16;
  localparam int unsigned VEC_LEN_DEF = Input_len;
  localparam int unsigned N_ROW_DEF   = Input_len;
  localparam int unsigned SUM_W_DEF   = 36;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SUB,
    EXP,
    DRAIN,
    ROWEND,
    DONE
  } phase_state_e;

endpackage

// File: rtl/softmax_phase_ctrl_if.sv
// softmax_phase_ctrl_if
//   Bundles the sequencer's control/data signals.
//   master : the sequencer (drives requests, address, xi, row sum, status)
//   slave  : the surrounding memories / LUT (drive start, data_in, exp_in/vld)
//   Optional macro SOFTMAX_CTRL_PERF_EN adds perf_cycles / perf_stall.
interface softmax_phase_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned EXP_W  = 32,
  parameter int unsigned SUM_W  = 36,
  parameter int unsigned ROW_W  = 4
);
  logic              start;
  logic [7:0]        data_in;
  logic [EXP_W-1:0]  exp_in;
  logic              exp_vld;
  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [7:0]        xi;
  logic              camsub_req;
  logic              findsub_req;
  logic              exp_req;
  logic [ROW_W-1:0]  row_idx;
  logic [SUM_W-1:0]  sum_exp;
  logic              sum_vld;
  logic              busy;
  logic              finish;
  logic              err_timeout;
`ifdef SOFTMAX_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
  logic [15:0]       perf_stall;
`endif

  modport master (
    input  start, data_in, exp_in, exp_vld,
`ifdef SOFTMAX_CTRL_PERF_EN
    output perf_cycles, perf_stall,
`endif
    output data_req, data_addr, xi, camsub_req, findsub_req, exp_req,
    output row_idx, sum_exp, sum_vld, busy, finish, err_timeout
  );

  modport slave (
    output start, data_in, exp_in, exp_vld,
`ifdef SOFTMAX_CTRL_PERF_EN
    input  perf_cycles, perf_stall,
`endif
    input  data_req, data_addr, xi, camsub_req, findsub_req, exp_req,
    input  row_idx, sum_exp, sum_vld, busy, finish, err_timeout
  );
endinterface

// File: rtl/softmax_sum_acc.sv
// softmax_sum_acc
//   Saturating row accumulator for returned exp values.
//   clk, rst : clock, async active-high reset
//   i_clr    : synchronous clear of sum and count (has priority)
//   i_en     : accept window (EXP/DRAIN phases)
//   i_vld    : i_exp valid this cycle
//   i_exp    : exp value to add
//   o_sum    : accumulated sum, saturating at 2^SUM_W-1
//   o_cnt    : number of accepted terms; stops at VEC_LEN (extras dropped)
module softmax_sum_acc #(
  parameter int unsigned EXP_W   = 32,
  parameter int unsigned SUM_W   = 36,
  parameter int unsigned VEC_LEN = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clr,
  input  logic                            i_en,
  input  logic                            i_vld,
  input  logic [EXP_W-1:0]                i_exp,
  output logic [SUM_W-1:0]                o_sum,
  output logic [$clog2(VEC_LEN+1)-1:0]    o_cnt
);
  localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
  localparam int unsigned AW    = ((SUM_W > EXP_W) ? SUM_W : EXP_W) + 1;
  localparam logic [AW-1:0] SAT_MAX = (AW'(1) << SUM_W) - AW'(1);

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    w_add;
  logic             w_take;

  assign w_take = i_en && i_vld && (r_cnt < CNT_W'(VEC_LEN));
  assign w_add  = AW'(r_sum) + AW'(i_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_sum <= (w_add > SAT_MAX) ? '1 : w_add[SUM_W-1:0];
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sum = r_sum;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/softmax_phase_ctrl.sv
// softmax_phase_ctrl
//   Row-by-row sequencer for the STAR softmax datapath: FETCH (read + CAMSUB),
//   SUB (FindSub), EXP (LUT lookup), DRAIN (collect exp results with a
//   watchdog), ROWEND (publish row sum).
//   clk, rst : clock, async active-high reset
//   io_bus   : softmax_phase_ctrl_if.master (start, data_in, exp_in/vld in;
//              data_req/addr, xi, phase strobes, row_idx, sum_exp/vld,
//              busy, finish, err_timeout out)
//   Optional macro SOFTMAX_CTRL_PERF_EN adds perf_cycles/perf_stall counters.
module softmax_phase_ctrl
  import softmax_phase_ctrl_pkg::*;
#(
  parameter int unsigned VEC_LEN = VEC_LEN_DEF,
  parameter int unsigned N_ROW   = N_ROW_DEF,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned EXP_W   = 32,
  parameter int unsigned SUM_W   = SUM_W_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  softmax_phase_ctrl_if.master io_bus
);
  localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;

  phase_state_e     r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [ROW_W-1:0] r_row;
  logic [7:0]       r_xi;
  logic             r_finish, r_err;

  logic             w_start_acc, w_acc_clr, w_acc_en, w_last_row;
  logic             w_drain_done, w_wd_expire;
  logic             w_data_req, w_camsub, w_findsub, w_exp_req, w_sum_vld, w_busy;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_exp_cnt;

  assign w_start_acc  = (r_state == IDLE) && io_bus.start;
  assign w_acc_clr    = w_start_acc || (r_state == ROWEND);
  assign w_acc_en     = (r_state == EXP) || (r_state == DRAIN);
  assign w_last_row   = (r_row == ROW_W'(N_ROW - 1));
  assign w_drain_done = (w_exp_cnt == CNT_W'(VEC_LEN));
  assign w_wd_expire  = (r_wd == WD_W'(TIMEOUT - 1));

  softmax_sum_acc #(
    .EXP_W   (EXP_W),
    .SUM_W   (SUM_W),
    .VEC_LEN (VEC_LEN)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_vld (io_bus.exp_vld),
    .i_exp (io_bus.exp_in),
    .o_sum (w_sum),
    .o_cnt (w_exp_cnt)
  );

  always_comb begin
    w_next     = r_state;
    w_data_req = 1'b0;
    w_camsub   = 1'b0;
    w_findsub  = 1'b0;
    w_exp_req  = 1'b0;
    w_sum_vld  = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (io_bus.start) w_next = FETCH;
      end
      // Read request runs one cycle ahead of the CAMSUB strobe.
      FETCH: begin
        w_data_req = (r_cnt < CNT_W'(VEC_LEN));
        w_camsub   = (r_cnt != '0);
        if (r_cnt == CNT_W'(VEC_LEN)) w_next = SUB;
      end
      SUB: begin
        w_findsub = 1'b1;
        if (r_cnt == CNT_W'(VEC_LEN - 1)) w_next = EXP;
      end
      EXP: begin
        w_exp_req = 1'b1;
        if (r_cnt == CNT_W'(VEC_LEN - 1)) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_drain_done || w_wd_expire) w_next = ROWEND;
      end
      ROWEND: begin
        w_sum_vld = 1'b1;
        w_next    = w_last_row ? DONE : FETCH;
      end
      DONE: begin
        w_busy = 1'b0;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wd     <= '0;
      r_row    <= '0;
      r_xi     <= '0;
      r_finish <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;

      // Phase counter restarts on every state change.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == FETCH || r_state == SUB || r_state == EXP)
        r_cnt <= r_cnt + CNT_W'(1);

      r_wd <= (r_state == DRAIN) ? r_wd + WD_W'(1) : '0;

      if (w_camsub) r_xi <= io_bus.data_in;

      if (w_start_acc) begin
        r_row    <= '0;
        r_finish <= 1'b0;
        r_err    <= 1'b0;
      end else begin
        if (r_state == DRAIN && !w_drain_done && w_wd_expire) r_err <= 1'b1;
        if (r_state == ROWEND) begin
          if (w_last_row) r_finish <= 1'b1;
          else            r_row    <= r_row + ROW_W'(1);
        end
      end
    end
  end

  assign io_bus.data_req    = w_data_req;
  assign io_bus.data_addr   = w_data_req ?
                              (ADDR_W'(r_row) * ADDR_W'(VEC_LEN) + ADDR_W'(r_cnt)) : '0;
  assign io_bus.xi          = r_xi;
  assign io_bus.camsub_req  = w_camsub;
  assign io_bus.findsub_req = w_findsub;
  assign io_bus.exp_req     = w_exp_req;
  assign io_bus.row_idx     = r_row;
  assign io_bus.sum_exp     = w_sum;
  assign io_bus.sum_vld     = w_sum_vld;
  assign io_bus.busy        = w_busy;
  assign io_bus.finish      = r_finish;
  assign io_bus.err_timeout = r_err;

`ifdef SOFTMAX_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_start_acc) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_busy && r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (r_state == DRAIN && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign io_bus.perf_cycles = r_perf_cycles;
  assign io_bus.perf_stall  = r_perf_stall;
`endif
endmodule

// File: tb/tb_softmax_phase_ctrl.sv
// tb_softmax_phase_ctrl
//   Directed bench for softmax_phase_ctrl.  u_dut: 16 rows, SUM_W=36.
//   u_sat: 1 row, SUM_W=34.  Memory and LUT responders model data_in one
//   cycle after data_req (addr low byte) and exp_vld two cycles after exp_req.
module tb_softmax_phase_ctrl;
  logic        clk, rst;
  int          tests, fails;
  logic [31:0] exp_val_m, exp_val_s;
  int          drop_tag_m;

  softmax_phase_ctrl_if #(.ADDR_W(9), .EXP_W(32), .SUM_W(36), .ROW_W(4)) mb ();
  softmax_phase_ctrl_if #(.ADDR_W(9), .EXP_W(32), .SUM_W(34), .ROW_W(1)) sb ();

  softmax_phase_ctrl #(.VEC_LEN(16), .N_ROW(16), .ADDR_W(9), .EXP_W(32),
                       .SUM_W(36), .TIMEOUT(64)) u_dut (.clk(clk), .rst(rst), .io_bus(mb));
  softmax_phase_ctrl #(.VEC_LEN(16), .N_ROW(1), .ADDR_W(9), .EXP_W(32),
                       .SUM_W(34), .TIMEOUT(64)) u_sat (.clk(clk), .rst(rst), .io_bus(sb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input memories: data_in = low byte of the address requested last cycle.
  initial begin : mem_m
    logic pr; logic [8:0] pa;
    pr = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      mb.data_in = pr ? pa[7:0] : 8'h00;
      pr = mb.data_req; pa = mb.data_addr;
    end
  end
  initial begin : mem_s
    logic pr; logic [8:0] pa;
    pr = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      sb.data_in = pr ? pa[7:0] : 8'h00;
      pr = sb.data_req; pa = sb.data_addr;
    end
  end

  // LUT responders: one result two cycles after each exp_req; the main one
  // can withhold the result tagged row*16+element == drop_tag_m.
  initial begin : lut_m
    int h0, h1, e;
    h0 = -1; h1 = -1; e = 0;
    forever begin
      @(negedge clk);
      if (h1 >= 0 && h1 != drop_tag_m) begin mb.exp_vld = 1'b1; mb.exp_in = exp_val_m; end
      else begin mb.exp_vld = 1'b0; mb.exp_in = '0; end
      h1 = h0;
      if (mb.exp_req) begin h0 = int'(mb.row_idx) * 16 + e; e++; end
      else begin h0 = -1; e = 0; end
    end
  end
  initial begin : lut_s
    logic h0, h1;
    h0 = 1'b0; h1 = 1'b0;
    forever begin
      @(negedge clk);
      sb.exp_vld = h1;
      sb.exp_in  = h1 ? exp_val_s : '0;
      h1 = h0;
      h0 = sb.exp_req;
    end
  end

  task automatic pulse_start_m();
    @(negedge clk); mb.start = 1'b1;
    @(negedge clk); mb.start = 1'b0;
  endtask

  task automatic pulse_start_s();
    @(negedge clk); sb.start = 1'b1;
    @(negedge clk); sb.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({mb.busy, mb.finish, mb.err_timeout, mb.data_req, mb.camsub_req, mb.findsub_req,
         mb.exp_req, mb.sum_vld} !== 8'b0) begin
      fails++; $display("FAIL reset_ctrl_m got=%b exp=00000000", {mb.busy, mb.finish,
        mb.err_timeout, mb.data_req, mb.camsub_req, mb.findsub_req, mb.exp_req, mb.sum_vld});
    end
    tests++;
    if (mb.data_addr !== 9'd0 || mb.xi !== 8'd0 || mb.row_idx !== 4'd0 || mb.sum_exp !== 36'd0) begin
      fails++; $display("FAIL reset_data_m addr=%h xi=%h row=%h sum=%h exp=all 0",
                        mb.data_addr, mb.xi, mb.row_idx, mb.sum_exp);
    end
    tests++;
    if ({sb.busy, sb.finish, sb.err_timeout, sb.data_req, sb.camsub_req, sb.sum_vld,
         sb.xi, sb.sum_exp} !== '0) begin
      fails++; $display("FAIL reset_s busy=%b fin=%b xi=%h sum=%h exp=all 0",
                        sb.busy, sb.finish, sb.xi, sb.sum_exp);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  // Cycle-exact single-row run on u_sat with exp_in=1; optionally a second
  // start pulse at cycle extra_t which must not disturb anything.
  task automatic test_single_row(input int extra_t);
    logic [6:0] got, expv;
    exp_val_s = 32'd1;
    pulse_start_s();
    for (int t = 0; t < 56; t++) begin
      expv = {t < 16, (t >= 1) && (t <= 16), (t >= 17) && (t <= 32),
              (t >= 33) && (t <= 48), t == 52, t <= 52, t >= 53};
      got  = {sb.data_req, sb.camsub_req, sb.findsub_req, sb.exp_req,
              sb.sum_vld, sb.busy, sb.finish};
      tests++;
      if (got !== expv) begin
        fails++; $display("FAIL single_ctrl t=%0d extra=%0d got=%b exp=%b", t, extra_t, got, expv);
      end
      if (t < 16) begin
        tests++;
        if (sb.data_addr !== 9'(t)) begin
          fails++; $display("FAIL single_addr t=%0d got=%0d exp=%0d", t, sb.data_addr, t);
        end
      end
      if (t == 10 || t == 17 || t == 32) begin
        tests++;
        if (sb.xi !== ((t == 10) ? 8'd8 : 8'd15)) begin
          fails++; $display("FAIL single_xi t=%0d got=%0d exp=%0d", t, sb.xi, (t == 10) ? 8 : 15);
        end
      end
      if (t == 52) begin
        tests++;
        if (sb.sum_exp !== 34'd16) begin
          fails++; $display("FAIL single_sum got=%0d exp=16", sb.sum_exp);
        end
      end
      sb.start = (t == extra_t);
      @(negedge clk);
    end
    sb.start = 1'b0;
  endtask

  task automatic test_saturate();
    int n;
    exp_val_s = 32'hFFFF_FFFF;
    pulse_start_s();
    n = 0;
    while (!sb.sum_vld && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (!sb.sum_vld) begin
      fails++; $display("FAIL sat_sumvld_timeout got=0 exp=1");
    end else if (sb.sum_exp !== 34'h3_FFFF_FFFF) begin
      fails++; $display("FAIL sat_sum got=%h exp=3ffffffff", sb.sum_exp);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (sb.finish !== 1'b1 || sb.busy !== 1'b0) begin
      fails++; $display("FAIL sat_finish fin=%b busy=%b exp fin=1 busy=0", sb.finish, sb.busy);
    end
  endtask

  // Full 16-row run; row 3 loses its last exp result and must time out.
  task automatic test_full_run();
    int addr_n, pulses, d0, err_delay, cyc;
    logic prev_exp;
    exp_val_m = 32'd1;
    drop_tag_m = 3 * 16 + 15;
    addr_n = 0; pulses = 0; d0 = -1; err_delay = -1; cyc = 0; prev_exp = 1'b0;
    pulse_start_m();
    while (!mb.finish && cyc < 3000) begin
      if (mb.data_req) begin
        tests++;
        if (mb.data_addr !== 9'(addr_n) || mb.row_idx !== 4'(addr_n / 16)) begin
          fails++; $display("FAIL full_addr got=%0d/row%0d exp=%0d/row%0d",
                            mb.data_addr, mb.row_idx, addr_n, addr_n / 16);
        end
        addr_n++;
      end
      tests++;
      if ($countones({mb.camsub_req, mb.findsub_req, mb.exp_req}) > 1) begin
        fails++; $display("FAIL full_onehot cyc=%0d got=%b exp=at most one",
                          cyc, {mb.camsub_req, mb.findsub_req, mb.exp_req});
      end
      if (prev_exp && !mb.exp_req) d0 = cyc;
      if (mb.err_timeout && err_delay < 0) err_delay = cyc - d0;
      if (mb.sum_vld) begin
        tests++;
        if (mb.row_idx !== 4'(pulses) || mb.sum_exp !== ((pulses == 3) ? 36'd15 : 36'd16) ||
            mb.err_timeout !== (pulses >= 3)) begin
          fails++; $display("FAIL full_row%0d row=%0d sum=%0d err=%b exp row=%0d sum=%0d err=%b",
                            pulses, mb.row_idx, mb.sum_exp, mb.err_timeout, pulses,
                            (pulses == 3) ? 15 : 16, pulses >= 3);
        end
        pulses++;
      end
      prev_exp = mb.exp_req;
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (mb.finish !== 1'b1 || mb.busy !== 1'b0) begin
      fails++; $display("FAIL full_finish fin=%b busy=%b exp fin=1 busy=0", mb.finish, mb.busy);
    end
    tests++;
    if (addr_n != 256 || pulses != 16) begin
      fails++; $display("FAIL full_counts addrs=%0d sums=%0d exp 256/16", addr_n, pulses);
    end
    tests++;
    if (err_delay != 64) begin
      fails++; $display("FAIL full_timeout_delay got=%0d exp=64", err_delay);
    end
    drop_tag_m = -1;
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic seen_vld;
    exp_val_m = 32'd1;
    pulse_start_m();
    n = 0;
    while (!(mb.row_idx == 4'd5 && mb.exp_req) && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (!(mb.row_idx == 4'd5 && mb.exp_req)) begin
      fails++; $display("FAIL rst_reach_row5 got row=%0d exp_req=%b exp row=5 exp_req=1",
                        mb.row_idx, mb.exp_req);
    end
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({mb.busy, mb.exp_req, mb.data_req, mb.sum_vld, mb.finish, mb.err_timeout} !== 6'b0 ||
        mb.row_idx !== 4'd0 || mb.xi !== 8'd0 || mb.sum_exp !== 36'd0) begin
      fails++; $display("FAIL rst_async busy=%b exp_req=%b row=%0d xi=%h sum=%h exp=all 0",
                        mb.busy, mb.exp_req, mb.row_idx, mb.xi, mb.sum_exp);
    end
    @(negedge clk); rst = 1'b0;
    seen_vld = 1'b0;
    repeat (10) begin @(negedge clk); seen_vld |= mb.sum_vld | mb.busy; end
    tests++;
    if (seen_vld !== 1'b0) begin
      fails++; $display("FAIL rst_quiet got sum_vld/busy=1 exp=0");
    end
    exp_val_m = 32'hFFFF_FFFF;
    pulse_start_m();
    tests++;
    if (mb.data_req !== 1'b1 || mb.data_addr !== 9'd0 || mb.row_idx !== 4'd0) begin
      fails++; $display("FAIL rst_restart req=%b addr=%0d row=%0d exp 1/0/0",
                        mb.data_req, mb.data_addr, mb.row_idx);
    end
    n = 0;
    while (!mb.sum_vld && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (!mb.sum_vld || mb.sum_exp !== 36'hF_FFFF_FFF0 || mb.row_idx !== 4'd0) begin
      fails++; $display("FAIL nosat_sum vld=%b got=%h row=%0d exp=ffffffff0 row=0",
                        mb.sum_vld, mb.sum_exp, mb.row_idx);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    tests = 0; fails = 0;
    mb.start = 1'b0; sb.start = 1'b0;
    exp_val_m = 32'd1; exp_val_s = 32'd1;
    drop_tag_m = -1;
    test_reset();
    test_single_row(-1);
    test_single_row(20);
    test_saturate();
    test_full_run();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/softmax_phase_ctrl.md
Name: softmax_phase_ctrl

Overview:
Sequencer for the STAR softmax datapath. It walks the input tensor row by row. For each row of VEC_LEN elements it drives, in order, the fetch/CAMSUB phase (max search and buffering), the FindSub phase (xi − max), and the EXP phase (one-hot to LUT lookup). It then accumulates the returned exp values into the row sum. It sits between the input memory and the CAMSUB/CAM/LUT memories and replaces the ad-hoc request sequencing in the top level.

Parameters:
VEC_LEN, 16, elements per row; power of two, ≥4.
N_ROW, 16, rows per run.
ADDR_W, 9, data_addr width; must be ≥ log2(VEC_LEN*N_ROW).
EXP_W, 32, exp value width.
SUM_W, 36, accumulator width.
TIMEOUT, 64, max cycles to wait for outstanding exp results per row.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse, begin run
data_in  in  8  input memory read data, valid the cycle after data_req
exp_in  in  EXP_W  LUT exp value
exp_vld  in  1  exp_in valid this cycle
data_req  out  1  input memory read request
data_addr  out  ADDR_W  read address
xi  out  8  registered element to CAMSUB memory
camsub_req  out  1  CAMSUB phase strobe
findsub_req  out  1  FindSub phase strobe
exp_req  out  1  EXP phase strobe
row_idx  out  log2(N_ROW)  current row
sum_exp  out  SUM_W  row exp sum; valid with sum_vld
sum_vld  out  1  one-cycle pulse per row
busy  out  1  run in progress
finish  out  1  sticky; set at end of run, cleared by next accepted start
err_timeout  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. All outputs reset to 0. xi resets to 0. FSM resets to IDLE. Counters and accumulator reset to 0. Reset asserted mid-run aborts immediately; no partial sum_vld is produced.
- States: IDLE → FETCH → SUB → EXP → DRAIN → ROWEND → (FETCH for the next row | DONE) → IDLE.
- IDLE: a start pulse clears finish, err_timeout, row_idx and the accumulator, sets busy, and moves to FETCH. A start pulse received while busy is ignored.
- FETCH: lasts VEC_LEN+1 cycles.
  - Cycles 0..VEC_LEN-1: data_req=1 and data_addr=row_idx*VEC_LEN+k.
  - Cycles 1..VEC_LEN: xi<=data_in and camsub_req=1.
  - Result: camsub_req is high for exactly VEC_LEN consecutive cycles, with data_req leading it by one cycle.
- SUB: findsub_req=1 for exactly VEC_LEN cycles, starting the cycle after the last camsub_req. xi holds its last value.
- EXP: exp_req=1 for exactly VEC_LEN cycles.
- Accumulation: from the first EXP cycle onward, every cycle with exp_vld=1 adds exp_in to the accumulator and increments exp_cnt.
  - The addition saturates at 2^SUM_W−1; there is no wrap.
  - exp_vld outside the EXP and DRAIN states is ignored.
- DRAIN: waits until exp_cnt==VEC_LEN. A watchdog counts cycles from EXP exit. If it reaches TIMEOUT, err_timeout is set and the FSM proceeds anyway.
- ROWEND: sum_vld=1 for one cycle, with sum_exp holding the accumulator. The accumulator and exp_cnt clear in the same cycle. If row_idx==N_ROW-1, go to DONE; otherwise increment row_idx and go to FETCH.
- DONE: busy=0 and finish=1 (sticky). Next state is IDLE.
- Invariants:
  - At most one of camsub_req, findsub_req, exp_req is high in any cycle.
  - There are no idle cycles between consecutive phases.
  - data_addr never exceeds VEC_LEN*N_ROW−1.
- Extra exp results: exp_vld beyond VEC_LEN in a row is dropped.

Optional Feature:
SOFTMAX_CTRL_PERF_EN.
- Defined: adds output perf_cycles[31:0] and output perf_stall[15:0].
  - perf_cycles counts clk cycles while busy, saturating, cleared on accepted start.
  - perf_stall counts DRAIN cycles, saturating, cleared on accepted start.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Add to the shared def package:
  - typedef enum phase_state_e {IDLE, FETCH, SUB, EXP, DRAIN, ROWEND, DONE}.
  - VEC_LEN and N_ROW defaults, tied to Input_len.
  - The SUM_W constant.
- One sub-module, softmax_sum_acc: the saturating accumulator with exp_cnt and clear. The FSM, address generation and watchdog stay in softmax_phase_ctrl.

Test Plan:
- Single row (N_ROW=1), data_in=address low byte, exp_in=1 with exp_vld 2 cycles after each exp_req → camsub/findsub/exp_req each 16 cycles back-to-back; sum_exp=16, sum_vld once, then finish=1.
- N_ROW=16 → data_addr covers 0..255 in order; row_idx 0..15; 16 sum_vld pulses; finish after the last.
- exp_vld withheld for the last element of row 3 → err_timeout=1 64 cycles after EXP exit; row 3 sum covers 15 terms; run completes.
- SUM_W=36, exp_in=32'hFFFF_FFFF for all 16 → sum_exp=0xF_FFFF_FFF0 (no saturation); with SUM_W=34 → saturates to 0x3_FFFF_FFFF.
- start pulsed during SUB → ignored; waveform identical to a single start.
- rst asserted mid-EXP of row 5 → all outputs 0 in the same cycle; a new start restarts at row 0, data_addr 0.
